// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port identifiers for the RAM bus arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - one requester port of the RAM bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (output req, we, addr, wdata, input rdata, done);
  modport slave  (input req, we, addr, wdata, output rdata, done);

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin chooser
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    // On a tie the port that did not win last time goes next.
    if (req0_i && req1_i) begin
      gnt_id_o = (last_gnt_i == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else begin
      gnt_id_o = req1_i ? PORT_DMA : PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one RAM bus between the CPU (port 0) and DMA/loader (port 1)
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic              ram_oe_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o,
  output logic              gnt_id_o
);

  localparam int              CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_gnt_q;
  logic              gnt_id_q;
  logic              busy_q;
  logic              ram_cs_q;
  logic              ram_we_q;
  logic              ram_oe_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              done0_q;
  logic              done1_q;
  logic              pick_valid;
  logic              pick_id;

  rr_pick2 u_pick (
    .req0_i      (m0.req),
    .req1_i      (m1.req),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (pick_valid),
    .gnt_id_o    (pick_id)
  );

  // The ram_* registers double as the latched request fields.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= PORT_DMA;
      gnt_id_q    <= PORT_CPU;
      busy_q      <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= ACCESS;
            gnt_id_q   <= pick_id;
            last_gnt_q <= pick_id;
            cnt_q      <= CNT_LOAD;
            busy_q     <= 1'b1;
            ram_cs_q   <= 1'b1;
            if (pick_id == PORT_CPU) begin
              ram_we_q    <= m0.we;
              ram_oe_q    <= !m0.we;
              ram_addr_q  <= m0.addr;
              ram_wdata_q <= m0.we ? m0.wdata : '0;
            end else begin
              ram_we_q    <= m1.we;
              ram_oe_q    <= !m1.we;
              ram_addr_q  <= m1.addr;
              ram_wdata_q <= m1.we ? m1.wdata : '0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!ram_we_q) begin
              if (gnt_id_q == PORT_CPU) rdata0_q <= ram_rdata_i;
              else                      rdata1_q <= ram_rdata_i;
            end
            done0_q     <= (gnt_id_q == PORT_CPU);
            done1_q     <= (gnt_id_q == PORT_DMA);
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0.rdata    = rdata0_q;
  assign m0.done     = done0_q;
  assign m1.rdata    = rdata1_q;
  assign m1.done     = done1_q;
  assign ram_cs_o    = ram_cs_q;
  assign ram_we_o    = ram_we_q;
  assign ram_oe_o    = ram_oe_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign busy_o      = busy_q;
  assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;

  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) a0 ();
  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) a1 ();
  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b0 ();
  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();

  logic        a_cs, a_we, a_oe, a_busy, a_gnt;
  logic        b_cs, b_we, b_oe, b_busy, b_gnt;
  logic [63:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata;
  wire  [63:0] b_rdata = 64'hB0B0_B0B0_1234_5678;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RAM_LAT(LAT_A)) u_dut_a (
    .clk_i(clk), .reset_ni(rst_a_n), .m0(a0), .m1(a1),
    .ram_cs_o(a_cs), .ram_we_o(a_we), .ram_oe_o(a_oe), .ram_addr_o(a_addr),
    .ram_wdata_o(a_wdata), .ram_rdata_i(a_rdata), .busy_o(a_busy), .gnt_id_o(a_gnt)
  );

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .RAM_LAT(LAT_B)) u_dut_b (
    .clk_i(clk), .reset_ni(rst_b_n), .m0(b0), .m1(b1),
    .ram_cs_o(b_cs), .ram_we_o(b_we), .ram_oe_o(b_oe), .ram_addr_o(b_addr),
    .ram_wdata_o(b_wdata), .ram_rdata_i(b_rdata), .busy_o(b_busy), .gnt_id_o(b_gnt)
  );

  wire [262:0] a_all = {a_cs, a_we, a_oe, a_busy, a_gnt, a0.done, a1.done,
                        a_addr, a_wdata, a0.rdata, a1.rdata};
  wire [262:0] b_all = {b_cs, b_we, b_oe, b_busy, b_gnt, b0.done, b1.done,
                        b_addr, b_wdata, b0.rdata, b1.rdata};

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem_a   [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  int          a_cs_cnt = 0;

  function automatic logic [63:0] dflt(input logic [63:0] addr);
    return {addr[31:0] ^ 32'hA5A5_0F0F, addr[63:32] ^ ~addr[31:0]};
  endfunction

  function automatic logic [63:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
    return 64'($urandom_range(0, 15)) << 3;
  endfunction

  // RAM model: data is only valid in the last chip-select cycle of an access.
  always @(posedge clk) begin
    if (a_cs && a_we) mem_a[a_addr] = a_wdata;
    a_cs_cnt = a_cs ? a_cs_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (a_cs && a_cs_cnt == LAT_A - 1)
      a_rdata = mem_a.exists(a_addr) ? mem_a[a_addr] : dflt(a_addr);
    else
      a_rdata = 64'hBAD0_BAD0_0000_0000 | 64'(a_cs_cnt);
  end

  task automatic drive_a(input int p, input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
    if (p == 0) begin
      a0.req = req; a0.we = we; a0.addr = addr; a0.wdata = wdata;
    end else begin
      a1.req = req; a1.we = we; a1.addr = addr; a1.wdata = wdata;
    end
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive_a(0, 1'b1, 1'b0, 64'h10, 64'h0);
    drive_a(1, 1'b1, 1'b1, 64'h20, 64'h55);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 64'h30; b0.wdata = 64'h0;
    b1.req = 1'b1; b1.we = 1'b1; b1.addr = 64'h40; b1.wdata = 64'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_all !== '0) begin n_err++; $display("FAIL reset_a: got %h want 0", a_all); end
      n_vec++;
      if (b_all !== '0) begin n_err++; $display("FAIL reset_b: got %h want 0", b_all); end
    end
    drive_a(0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_a(1, 1'b0, 1'b0, 64'h0, 64'h0);
    b0.req = 1'b0; b1.req = 1'b0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
  endtask

  task automatic test_port0_read;
    mem_a[64'h100] = 64'hDEADBEEF00000013;
    drive_a(0, 1'b1, 1'b0, 64'h100, 64'h0);
    for (int i = 0; i < 5; i++) begin
      logic ecs;
      ecs = (i == 1 || i == 2);
      @(negedge clk);
      n_vec++;
      if ({a_cs, a_we, a_oe} !== {ecs, 1'b0, ecs}) begin
        n_err++; $display("FAIL rd_ctl cyc%0d: got %b want %b", i, {a_cs, a_we, a_oe}, {ecs, 1'b0, ecs});
      end
      n_vec++;
      if (a_addr !== (ecs ? 64'h100 : 64'h0)) begin
        n_err++; $display("FAIL rd_addr cyc%0d: got %h", i, a_addr);
      end
      n_vec++;
      if ({a_busy, a0.done, a1.done} !== {(i >= 1 && i <= 3), (i == 3), 1'b0}) begin
        n_err++; $display("FAIL rd_status cyc%0d: got %b", i, {a_busy, a0.done, a1.done});
      end
      if (i >= 3) begin
        n_vec++;
        if (a0.rdata !== 64'hDEADBEEF00000013) begin
          n_err++; $display("FAIL rd_data cyc%0d: got %h want deadbeef00000013", i, a0.rdata);
        end
      end
      @(posedge clk); #1;
      if (i == 3) a0.req = 1'b0;
    end
  endtask

  task automatic test_port1_write;
    drive_a(1, 1'b1, 1'b1, 64'h2000, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      logic ecs;
      ecs = (i == 1 || i == 2);
      @(negedge clk);
      n_vec++;
      if ({a_cs, a_we, a_oe} !== {ecs, ecs, 1'b0}) begin
        n_err++; $display("FAIL wr_ctl cyc%0d: got %b want %b", i, {a_cs, a_we, a_oe}, {ecs, ecs, 1'b0});
      end
      n_vec++;
      if ({a_addr, a_wdata} !== (ecs ? {64'h2000, 64'h1234} : 128'h0)) begin
        n_err++; $display("FAIL wr_bus cyc%0d: got %h %h", i, a_addr, a_wdata);
      end
      n_vec++;
      if ({a_busy, a_gnt, a0.done, a1.done} !== {(i >= 1 && i <= 3), (i >= 1), 1'b0, (i == 3)}) begin
        n_err++; $display("FAIL wr_status cyc%0d: got %b", i, {a_busy, a_gnt, a0.done, a1.done});
      end
      n_vec++;
      if ({a0.rdata, a1.rdata} !== {64'hDEADBEEF00000013, 64'h0}) begin
        n_err++; $display("FAIL wr_rdata_hold cyc%0d: got %h %h", i, a0.rdata, a1.rdata);
      end
      @(posedge clk); #1;
      if (i == 3) a1.req = 1'b0;
    end
  endtask

  task automatic test_contention;
    drive_a(0, 1'b1, 1'b0, 64'h40, 64'h0);
    drive_a(1, 1'b1, 1'b0, 64'h88, 64'h0);
    for (int i = 0; i < 17; i++) begin
      int n, ph;
      logic own, egnt;
      n = i / 4;
      ph = i % 4;
      own = 1'(n % 2);
      egnt = (ph != 0) ? own : ((n == 0) ? 1'b1 : 1'((n - 1) % 2));
      if (i == 16) begin ph = 0; egnt = 1'b1; end
      @(negedge clk);
      n_vec++;
      if ({a_gnt, a_busy, a0.done, a1.done} !== {egnt, ph != 0, ph == 3 && !own, ph == 3 && own}) begin
        n_err++; $display("FAIL cont_status cyc%0d: got %b want %b", i,
          {a_gnt, a_busy, a0.done, a1.done}, {egnt, ph != 0, ph == 3 && !own, ph == 3 && own});
      end
      n_vec++;
      if ({a_cs, a_addr} !== ((ph == 1 || ph == 2) ? {1'b1, (own ? 64'h88 : 64'h40)} : 65'h0)) begin
        n_err++; $display("FAIL cont_bus cyc%0d: got %b %h", i, a_cs, a_addr);
      end
      if (ph == 3) begin
        n_vec++;
        if ((own ? a1.rdata : a0.rdata) !== dflt(own ? 64'h88 : 64'h40)) begin
          n_err++; $display("FAIL cont_rdata cyc%0d: got %h want %h", i,
            own ? a1.rdata : a0.rdata, dflt(own ? 64'h88 : 64'h40));
        end
      end
      @(posedge clk); #1;
      if (i == 15) begin a0.req = 1'b0; a1.req = 1'b0; end
    end
  endtask

  task automatic test_abandon;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    drive_a(0, 1'b1, 1'b1, 64'h300, wd);
    for (int i = 0; i < 7; i++) begin
      logic ecs;
      ecs = (i == 1 || i == 2);
      @(negedge clk);
      n_vec++;
      if ({a_cs, a_we, a_oe, a_addr, a_wdata} !== (ecs ? {3'b110, 64'h300, wd} : 131'h0)) begin
        n_err++; $display("FAIL ab_bus cyc%0d: got %b %h %h", i, {a_cs, a_we, a_oe}, a_addr, a_wdata);
      end
      n_vec++;
      if ({a_busy, a_gnt, a0.done, a1.done} !== {(i >= 1 && i <= 3), (i == 0), (i == 3), 1'b0}) begin
        n_err++; $display("FAIL ab_status cyc%0d: got %b", i, {a_busy, a_gnt, a0.done, a1.done});
      end
      @(posedge clk); #1;
      if (i == 0) drive_a(0, 1'b0, 1'b0, 64'hFFF, ~wd);
    end
  endtask

  task automatic test_reset_access;
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 64'h500; b0.wdata = 64'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({b_cs, b_addr} !== ((i == 0) ? 65'h0 : {1'b1, 64'h500})) begin
        n_err++; $display("FAIL ra_pre cyc%0d: got %b %h", i, b_cs, b_addr);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    #1;
    rst_b_n = 1'b0;
    b0.req = 1'b0;
    b1.req = 1'b1; b1.we = 1'b1; b1.addr = 64'h600; b1.wdata = 64'h77;
    #1;
    n_vec++;
    if (b_all !== '0) begin n_err++; $display("FAIL ra_async_drop: got %h want 0", b_all); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (b_all !== '0) begin n_err++; $display("FAIL ra_held cyc%0d: got %h want 0", i, b_all); end
    end
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic ecs;
      ecs = (i >= 1 && i <= LAT_B);
      @(negedge clk);
      n_vec++;
      if ({b_cs, b_we, b_oe, b_addr, b_wdata} !== (ecs ? {3'b110, 64'h600, 64'h77} : 131'h0)) begin
        n_err++; $display("FAIL ra_bus cyc%0d: got %b %h %h", i, {b_cs, b_we, b_oe}, b_addr, b_wdata);
      end
      n_vec++;
      if ({b_busy, b_gnt, b0.done, b1.done, b0.rdata} !==
          {(i >= 1 && i <= LAT_B + 1), (i >= 1), 1'b0, (i == LAT_B + 1), 64'h0}) begin
        n_err++; $display("FAIL ra_status cyc%0d: got %b rdata0 %h", i,
          {b_busy, b_gnt, b0.done, b1.done}, b0.rdata);
      end
      @(posedge clk); #1;
      if (i == LAT_B + 1) b1.req = 1'b0;
    end
  endtask

  task automatic test_random(input int cycles);
    int          k = 0;
    logic        last = 1'b1, gout = 1'b0, own = 1'b0, owe = 1'b0;
    logic [63:0] oaddr = '0, owdata = '0;
    logic [63:0] exp_rd [2];
    rst_a_n = 1'b0;
    drive_a(0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_a(1, 1'b0, 1'b0, 64'h0, 64'h0);
    mem_a.delete();
    ref_mem.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      logic ecs, edone;
      int   dp;
      logic r0, r1;
      @(negedge clk);
      ecs = (k >= 1 && k <= LAT_A);
      edone = (k == LAT_A + 1);
      n_vec++;
      if ({a_cs, a_we, a_oe} !== {ecs, ecs && owe, ecs && !owe}) begin
        n_err++; $display("FAIL rnd_ctl cyc%0d: got %b want %b", c, {a_cs, a_we, a_oe}, {ecs, ecs && owe, ecs && !owe});
      end
      n_vec++;
      if ({a_addr, a_wdata} !== {(ecs ? oaddr : 64'h0), ((ecs && owe) ? owdata : 64'h0)}) begin
        n_err++; $display("FAIL rnd_bus cyc%0d: got %h %h want %h %h", c, a_addr, a_wdata,
          ecs ? oaddr : 64'h0, (ecs && owe) ? owdata : 64'h0);
      end
      n_vec++;
      if ({a_busy, a_gnt, a0.done, a1.done} !== {k != 0, gout, edone && !own, edone && own}) begin
        n_err++; $display("FAIL rnd_status cyc%0d: got %b want %b", c,
          {a_busy, a_gnt, a0.done, a1.done}, {k != 0, gout, edone && !own, edone && own});
      end
      n_vec++;
      if ({a0.rdata, a1.rdata} !== {exp_rd[0], exp_rd[1]}) begin
        n_err++; $display("FAIL rnd_rdata cyc%0d: got %h %h want %h %h", c,
          a0.rdata, a1.rdata, exp_rd[0], exp_rd[1]);
      end
      @(posedge clk);
      dp = edone ? int'(own) : -1;
      r0 = a0.req;
      r1 = a1.req;
      if (k == 0) begin
        if (r0 || r1) begin
          own = (r0 && r1) ? !last : r1;
          owe = own ? a1.we : a0.we;
          oaddr = own ? a1.addr : a0.addr;
          owdata = own ? a1.wdata : a0.wdata;
          last = own;
          gout = own;
          k = 1;
        end
      end else if (k <= LAT_A) begin
        if (k == LAT_A) begin
          if (owe) ref_mem[oaddr] = owdata;
          else exp_rd[own] = ref_mem.exists(oaddr) ? ref_mem[oaddr] : dflt(oaddr);
        end
        k++;
      end else begin
        k = 0;
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        logic rq;
        rq = (p == 0) ? a0.req : a1.req;
        if (dp == p) begin
          if ($urandom_range(0, 1) == 0) drive_a(p, 1'b0, 1'b0, 64'h0, 64'h0);
          else drive_a(p, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
        end else if (k != 0 && int'(own) == p) begin
          if (rq && $urandom_range(0, 7) == 0)
            drive_a(p, 1'b0, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
          else if (rq && $urandom_range(0, 1) == 0)
            drive_a(p, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
        end else if (!rq && $urandom_range(0, 2) == 0) begin
          drive_a(p, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_port0_read();
    test_port1_write();
    test_contention();
    test_abandon();
    test_reset_access();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single RAM bus (cs/we/oe, 64-bit address, 64-bit data) between two requesters: port 0 is the CPU core (instruction fetch plus ld/sd), port 1 is the DMA/debug program loader.
- Sequences each access as request, grant, a fixed number of RAM wait cycles, then a one-cycle done pulse.
- Sits between the core's memory interface and the RAM at the top level.
- Uses separate read and write data buses. The top level handles any tri-state merge, so the block contains no internal tristates.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- RAM_LAT, 1, number of cycles ram_cs is held per access; must be >= 1. Read data is valid in the last of these cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req  input  1  port 0 access request.
- m0_we  input  1  port 0: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  port 0 byte address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_rdata  output  DATA_W  port 0 registered read data.
- m0_done  output  1  port 0 one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done  same as port 0, for port 1.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data.
- busy  output  1  high in ACCESS and DONE.
- gnt_id  output  1  port owning the current or last transaction.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: all outputs are 0.
  - Internal state: state=IDLE, last_gnt=1 (so port 0 wins the first tie), latched request fields=0, wait counter=0.
- IDLE:
  - Requests are sampled only in this state.
  - Only one req high: grant that port.
  - Both req high: grant the port not equal to last_gnt (round-robin).
  - On grant, latch we/addr/wdata, set gnt_id and last_gnt, load counter=RAM_LAT-1, then go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - ram_cs=1, ram_we=latched we, ram_oe=!latched we, ram_addr=latched addr.
  - ram_wdata=latched wdata on writes, 0 on reads.
  - Counter decrements each cycle.
  - When counter==0: on a read, capture ram_rdata into the grantee's rdata register at that edge; then go to DONE.
- DONE:
  - ram_* outputs return to 0.
  - Grantee's done=1 for exactly one cycle; then go to IDLE.
- Outside ACCESS, ram_cs/we/oe/addr/wdata are all 0.
- Latency: req first high in an IDLE cycle t gives ACCESS in t+1..t+RAM_LAT and done in t+RAM_LAT+1. Minimum back-to-back period is RAM_LAT+2 cycles.
- Handshake:
  - A requester holds req and its fields stable until it sees done, then drops req at that edge.
  - If req is still high in the following IDLE cycle, that is a new transaction.
- Req deasserted after grant: the transaction still completes and done still pulses. Changes to the requester's inputs after grant are ignored.
- Read data retention:
  - mX_rdata holds its value until that port's next completed read.
  - Writes and the other port's reads never alter it.
- Reset mid-operation: outputs drop immediately; the in-flight access is abandoned with no done pulse. After release, pending requests are re-arbitrated from IDLE with last_gnt=1.
- No address alignment check; the address is passed through unmodified.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: IDLE, ACCESS, DONE.
  - Port ID constants: PORT_CPU=0, PORT_DMA=1.
- One natural sub-module: rr_pick2, a combinational two-way round-robin chooser (inputs: req0, req1, last_gnt; outputs: gnt_valid, gnt_id). Allows later expansion to more requesters.

Test Plan:
- Reset: hold reset=0 with both req=1 for 5 cycles. All outputs stay 0, busy=0, no done pulses.
- Port 0 read: RAM_LAT=2, m0_req=1, m0_addr=0x100, ram_rdata=0xDEADBEEF00000013 during ACCESS. Expect ram_cs=ram_oe=1 and ram_addr=0x100 for 2 cycles, ram_we=0, m0_done pulse on the 3rd cycle after req, m0_rdata=0xDEADBEEF00000013.
- Port 1 write: m1_addr=0x2000, m1_wdata=0x1234, m1_we=1. Expect ram_cs=ram_we=1, ram_wdata=0x1234 for RAM_LAT cycles, ram_oe=0, one m1_done pulse, m1_rdata and m0_rdata unchanged.
- Contention: both req held continuously (re-raised after each done). Expect gnt_id sequence 0,1,0,1 and alternating done pulses, each exactly one cycle.
- Reset in ACCESS: with RAM_LAT=3, assert reset in the 2nd ACCESS cycle. ram_cs drops in the same cycle with no done. After release with m1_req=1, a fresh full transaction is granted to port 1.
- Abandoned req: m0_req drops the cycle after grant. Expect the access to run the full RAM_LAT cycles, exactly one m0_done, and busy=0 afterward.
